regfile_bank: RTL and testbench

Integer register file for the veriRISCV core: the consumer end of the write-back interface driven by the write-back stage, and the registered source of both operands for the decode stage. It holds REG_NUM registers with register 0 hardwired to zero. After reset, a clear sequencer zeroes the storage one entry per cycle and signals readiness. An optional write-to-read forwarding path resolves the same-cycle write-back/read hazard inside the block.

---
 rtl/regfile_bank.sv | 108 ++++++++++
 tb/tb_regfile_bank.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_bank.sv
// Integer register file: x0 hardwired to zero, two registered read ports, one write-back port,
// post-reset clear sequencer. Optional same-edge write-to-read forwarding via RF_FORWARD_EN.
module regfile_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  localparam int RID_W     = $clog2(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_reg_write,
  input  logic [RID_W-1:0]      wb_reg_regid,
  input  logic [DATA_WIDTH-1:0] wb_reg_writedata,
  input  logic                  rf_read_en,
  input  logic [RID_W-1:0]      rs1_regid,
  input  logic [RID_W-1:0]      rs2_regid,
  output logic [DATA_WIDTH-1:0] rs1_readdata,
  output logic [DATA_WIDTH-1:0] rs2_readdata,
  output logic                  rf_ready
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t                  state_reg, state_next;
  logic [RID_W-1:0]        counter_reg, counter_next;
  logic [DATA_WIDTH-1:0]   mem [REG_NUM];
  logic                    mem_we;
  logic [RID_W-1:0]        mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    wb_commit;
  logic [RID_W-1:0]        rd_regid [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      counter_reg <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
    end
  end

  // The single memory write port is shared between the clear sequencer and write-back.
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    mem_we       = 1'b0;
    mem_waddr    = wb_reg_regid;
    mem_wdata    = wb_reg_writedata;
    wb_commit    = 1'b0;
    case (state_reg)
      CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = counter_reg;
        mem_wdata    = '0;
        counter_next = counter_reg + 1'b1;
        if (counter_reg == RID_W'(REG_NUM - 1)) begin
          state_next   = READY;
          counter_next = '0;
        end
      end
      READY: begin
        wb_commit = wb_reg_write && (wb_reg_regid != '0);
        mem_we    = wb_commit;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_regid[0] = rs1_regid;
  assign rd_regid[1] = rs2_regid;

  for (genvar gi = 0; gi < 2; gi++) begin : gen_rd
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] data_reg;

`ifdef RF_FORWARD_EN
    assign fwd_hit = wb_commit && (wb_reg_regid == rd_regid[gi]);
`else
    assign fwd_hit = 1'b0;
`endif

    // Storage read sees the pre-write value, so forwarding is the only way a same-edge write shows.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_reg <= '0;
      end else if (rf_read_en) begin
        if (rd_regid[gi] == '0 || state_reg == CLEAR) begin
          data_reg <= '0;
        end else if (fwd_hit) begin
          data_reg <= wb_reg_writedata;
        end else begin
          data_reg <= mem[rd_regid[gi]];
        end
      end
    end
  end

  assign rs1_readdata = gen_rd[0].data_reg;
  assign rs2_readdata = gen_rd[1].data_reg;
  assign rf_ready     = (state_reg == READY);

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: constant vector table, hand sequences for clear/reset,
// and randomized traffic compared every cycle against a behavioural register-file model.
module tb_regfile_bank;

  localparam int DW = 32;
  localparam int RN = 32;
  localparam int RW = 5;
`ifdef RF_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_reg_write;
  logic [RW-1:0] wb_reg_regid;
  logic [DW-1:0] wb_reg_writedata;
  logic          rf_read_en;
  logic [RW-1:0] rs1_regid;
  logic [RW-1:0] rs2_regid;
  logic [DW-1:0] rs1_readdata;
  logic [DW-1:0] rs2_readdata;
  logic          rf_ready;

  regfile_bank #(.DATA_WIDTH(DW), .REG_NUM(RN)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_reg_write     (wb_reg_write),
    .wb_reg_regid     (wb_reg_regid),
    .wb_reg_writedata (wb_reg_writedata),
    .rf_read_en       (rf_read_en),
    .rs1_regid        (rs1_regid),
    .rs2_regid        (rs2_regid),
    .rs1_readdata     (rs1_readdata),
    .rs2_readdata     (rs2_readdata),
    .rf_ready         (rf_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array plus "cycles of clearing done" count.
  logic [DW-1:0] m_mem [RN];
  bit            m_ready;
  int            m_cnt;
  logic [DW-1:0] m_rs1, m_rs2;

  typedef struct {
    logic          wr;
    logic [RW-1:0] wid;
    logic [DW-1:0] wdata;
    logic          ren;
    logic [RW-1:0] r1;
    logic [RW-1:0] r2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [RW-1:0] id);
    if (id == 0) return '0;
    if (FWD && wb_reg_write && wb_reg_regid == id) return wb_reg_writedata;
    return m_mem[id];
  endfunction

  // One clock: advance the model with the current inputs, then compare all outputs.
  task automatic tick(input string tag);
    logic [DW-1:0] n1, n2;
    n1 = m_rs1;
    n2 = m_rs2;
    if (rst) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      n1 = '0;
      n2 = '0;
    end else if (!m_ready) begin
      if (rf_read_en) begin
        n1 = '0;
        n2 = '0;
      end
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == RN) m_ready = 1'b1;
    end else begin
      if (rf_read_en) begin
        n1 = model_read(rs1_regid);
        n2 = model_read(rs2_regid);
      end
      if (wb_reg_write && wb_reg_regid != 0) m_mem[wb_reg_regid] = wb_reg_writedata;
    end
    m_rs1 = n1;
    m_rs2 = n2;
    @(posedge clk);
    #1;
    check({tag, "_rs1"}, rs1_readdata, m_rs1);
    check({tag, "_rs2"}, rs2_readdata, m_rs2);
    check({tag, "_ready"}, {31'b0, rf_ready}, {31'b0, m_ready});
  endtask

  task automatic drive(input logic wr, input logic [RW-1:0] wid, input logic [DW-1:0] wd,
                       input logic ren, input logic [RW-1:0] r1, input logic [RW-1:0] r2);
    wb_reg_write     = wr;
    wb_reg_regid     = wid;
    wb_reg_writedata = wd;
    rf_read_en       = ren;
    rs1_regid        = r1;
    rs2_regid        = r2;
  endtask

  initial begin
    for (int i = 0; i < RN; i++) m_mem[i] = '0;
    m_ready = 1'b0;
    m_cnt   = 0;
    m_rs1   = '0;
    m_rs2   = '0;

    vecs[0]  = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd7, 32'h0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd7, 5'd0, 32'hDEADBEEF, 32'h0};
    vecs[5]  = '{1'b1, 5'd3, 32'h22,       1'b1, 5'd0, 5'd3, 32'h0, FWD ? 32'h22 : 32'h11};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 32'h22, 32'h22};
    vecs[7]  = '{1'b1, 5'd4, 32'hAA,       1'b1, 5'd0, 5'd0, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd3, 32'hAA, 32'h22};
    vecs[9]  = '{1'b1, 5'd4, 32'hBB,       1'b0, 5'd9, 5'd3, 32'hAA, 32'h22};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 5'd3, 32'hAA, 32'h22};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd4, 32'hBB, 32'hBB};

    // Reset held 3 cycles, then clear with a continuous read of x5.
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
    #1;
    for (int i = 0; i < 3; i++) tick("reset");
    check("reset_rs1", rs1_readdata, 32'h0);
    check("reset_ready", {31'b0, rf_ready}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < RN; i++) begin
      tick("clear");
      check("clear_ready_edge", {31'b0, rf_ready}, (i == RN - 1) ? 32'h1 : 32'h0);
      check("clear_rs1_zero", rs1_readdata, 32'h0);
    end

    // Constant vector table.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].wr, vecs[i].wid, vecs[i].wdata, vecs[i].ren, vecs[i].r1, vecs[i].r2);
      tick("vec");
      check($sformatf("vec%0d_rs1", i), rs1_readdata, vecs[i].e1);
      check($sformatf("vec%0d_rs2", i), rs2_readdata, vecs[i].e2);
    end

    // Mid-run reset: x10 written, reset one cycle, write-back pulses during clear are ignored.
    drive(1'b1, 5'd10, 32'h55, 1'b0, 5'd0, 5'd0);
    tick("mid_wr");
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd0);
    tick("mid_rd");
    check("mid_pre_x10", rs1_readdata, 32'h55);
    rst = 1'b1;
    tick("mid_rst");
    check("mid_rst_rs1", rs1_readdata, 32'h0);
    check("mid_rst_ready", {31'b0, rf_ready}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < RN; i++) begin
      drive(i[0], 5'd10, 32'h77, 1'b1, 5'd10, 5'd10);
      tick("mid_clear");
    end
    check("mid_ready", {31'b0, rf_ready}, 32'h1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd0);
    tick("mid_post");
    check("mid_post_x10", rs1_readdata, 32'h0);

    // Randomized traffic with occasional resets, checked against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 7)),
            $urandom, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
